// File: rtl/pbs_turn_sched.sv
// Battle turn scheduler: one player+AI round per go edge, owns both HP registers
// and time-shares the move-table lookup port between the two trainers.
module pbs_turn_sched #(
  parameter int          HP_W      = 4,
  parameter int          MAX_HP    = 15,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            go,
  input  logic [1:0]      p_move,
  input  logic [HP_W-1:0] move_dmg,
  input  logic [HP_W-1:0] move_acc,
  output logic [1:0]      move_sel,
  output logic            active_trainer,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic [HP_W-1:0] last_dmg,
  output logic            hit,
  output logic            busy,
  output logic            victory,
  output logic            loss,
  output logic [3:0]      state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_P_WAIT    = 4'd1,
    S_P_LOOKUP  = 4'd2,
    S_P_APPLY   = 4'd3,
    S_P_CHECK   = 4'd4,
    S_AI_LOOKUP = 4'd5,
    S_AI_APPLY  = 4'd6,
    S_AI_CHECK  = 4'd7,
    S_WIN       = 4'd8,
    S_LOSE      = 4'd9
  } state_t;

  localparam logic [HP_W-1:0] HP_INIT = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0] ACC_ALL = {HP_W{1'b1}};

  state_t          state_q, state_nxt;
  logic [7:0]      lfsr;
  logic            lfsr_fb;
  logic            go_q, go_edge;
  logic [HP_W-1:0] roll;
  logic            roll_hit;
  logic [1:0]      move_sel_nxt;
  logic            at_nxt;
  logic [HP_W-1:0] p_hp_nxt, ai_hp_nxt, last_dmg_nxt;
  logic            hit_nxt;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                               input logic [HP_W-1:0] dmg);
    return (hp > dmg) ? hp - dmg : '0;
  endfunction

  // go is a plain level; a round starts on its rising edge, and only the
  // waiting/finished states consume it -- edges seen elsewhere are discarded.
  assign go_edge  = go & ~go_q;
  assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign roll     = HP_W'(lfsr[3:0]);
  assign roll_hit = (move_acc == ACC_ALL) | (roll < move_acc);

  assign state   = state_q;
  assign busy    = !(state_q inside {S_P_WAIT, S_WIN, S_LOSE});
  assign victory = (state_q == S_WIN);
  assign loss    = (state_q == S_LOSE);

  always_comb begin
    state_nxt    = state_q;
    move_sel_nxt = move_sel;
    at_nxt       = active_trainer;
    p_hp_nxt     = p_hp;
    ai_hp_nxt    = ai_hp;
    last_dmg_nxt = last_dmg;
    hit_nxt      = hit;
    case (state_q)
      S_IDLE: begin
        p_hp_nxt  = HP_INIT;
        ai_hp_nxt = HP_INIT;
        state_nxt = S_P_WAIT;
      end
      S_P_WAIT: begin
        if (go_edge) begin
          move_sel_nxt = p_move;
          state_nxt    = S_P_LOOKUP;
        end
      end
      S_P_LOOKUP: begin
        at_nxt    = 1'b0;
        state_nxt = S_P_APPLY;
      end
      // last_dmg reports the move's damage on a hit, even if HP saturates.
      S_P_APPLY: begin
        hit_nxt      = roll_hit;
        last_dmg_nxt = roll_hit ? move_dmg : '0;
        if (roll_hit) ai_hp_nxt = sat_sub(ai_hp, move_dmg);
        state_nxt    = S_P_CHECK;
      end
      S_P_CHECK: begin
        if (ai_hp == '0) begin
          state_nxt = S_WIN;
        end else begin
          move_sel_nxt = lfsr[7:6];
          state_nxt    = S_AI_LOOKUP;
        end
      end
      S_AI_LOOKUP: begin
        at_nxt    = 1'b1;
        state_nxt = S_AI_APPLY;
      end
      S_AI_APPLY: begin
        hit_nxt      = roll_hit;
        last_dmg_nxt = roll_hit ? move_dmg : '0;
        if (roll_hit) p_hp_nxt = sat_sub(p_hp, move_dmg);
        state_nxt    = S_AI_CHECK;
      end
      S_AI_CHECK: begin
        if (p_hp == '0) begin
          state_nxt = S_LOSE;
        end else begin
          at_nxt    = 1'b0;
          state_nxt = S_P_WAIT;
        end
      end
      S_WIN, S_LOSE: begin
        if (go_edge) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      p_hp           <= HP_INIT;
      ai_hp          <= HP_INIT;
      lfsr           <= LFSR_SEED;
      move_sel       <= 2'd0;
      active_trainer <= 1'b0;
      last_dmg       <= '0;
      hit            <= 1'b0;
      go_q           <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      p_hp           <= p_hp_nxt;
      ai_hp          <= ai_hp_nxt;
      lfsr           <= {lfsr[6:0], lfsr_fb};
      move_sel       <= move_sel_nxt;
      active_trainer <= at_nxt;
      last_dmg       <= last_dmg_nxt;
      hit            <= hit_nxt;
      go_q           <= go;
    end
  end

endmodule

// File: tb/tb_pbs_turn_sched.sv
// Bench for pbs_turn_sched: directed scenarios plus randomized games checked
// against a round-level game model driven by a reference roll sequence.
module tb_pbs_turn_sched;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_P_WAIT    = 4'd1;
  localparam logic [3:0] ST_P_LOOKUP  = 4'd2;
  localparam logic [3:0] ST_P_CHECK   = 4'd4;
  localparam logic [3:0] ST_AI_LOOKUP = 4'd5;
  localparam logic [3:0] ST_AI_APPLY  = 4'd6;
  localparam logic [3:0] ST_WIN       = 4'd8;
  localparam logic [3:0] ST_LOSE      = 4'd9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic [1:0] p_move = 2'd0;
  logic [3:0] move_dmg, move_acc;
  logic [1:0] move_sel;
  logic       active_trainer, hit, busy, victory, loss;
  logic [3:0] p_hp, ai_hp, last_dmg, state;

  logic [3:0] dmg_tab [4];
  logic [3:0] acc_tab [4];

  int n_checks = 0;
  int n_fail   = 0;

  // game model
  logic [7:0] m_lfsr;
  int         m_p, m_ai, m_over;

  always #5 clk = ~clk;

  assign move_dmg = dmg_tab[move_sel];
  assign move_acc = acc_tab[move_sel];

  pbs_turn_sched dut (
    .clk(clk), .reset_n(reset_n), .go(go), .p_move(p_move),
    .move_dmg(move_dmg), .move_acc(move_acc), .move_sel(move_sel),
    .active_trainer(active_trainer), .p_hp(p_hp), .ai_hp(ai_hp),
    .last_dmg(last_dmg), .hit(hit), .busy(busy), .victory(victory),
    .loss(loss), .state(state)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic bit hit_rule(input int acc, input int roll);
    return (acc == 15) || (roll < acc);
  endfunction

  function automatic int sat(input int hp, input int d);
    return (hp > d) ? hp - d : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_tab(input logic [3:0] d, input logic [3:0] a);
    for (int i = 0; i < 4; i++) begin
      dmg_tab[i] = d;
      acc_tab[i] = a;
    end
  endtask

  task automatic wait_p_wait(input string tag);
    int k;
    k = 0;
    while (state !== ST_P_WAIT && k < 3) begin
      @(negedge clk);
      k++;
    end
    check(tag, state, ST_P_WAIT);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    go = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_state", state, ST_IDLE);
    check("rst_victory", victory, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rel_state", state, ST_P_WAIT);
    check("rel_busy", busy, 0);
    check("rel_p_hp", p_hp, 15);
    check("rel_ai_hp", ai_hp, 15);
    m_p = 15; m_ai = 15; m_over = 0;
  endtask

  // Plays one round from P_WAIT; go rises at the negedge of cycle N.
  task automatic run_round(input logic [1:0] mv, input bit hold, input bit busy_pulse);
    logic [7:0] lf;
    logic [1:0] am;
    bit         h1, h2;
    int         d1, d2;
    check("pre_state", state, ST_P_WAIT);
    lf = m_lfsr;
    lf = lfsr_step(lfsr_step(lf));
    h1 = hit_rule(acc_tab[mv], lf[3:0]);
    d1 = h1 ? int'(dmg_tab[mv]) : 0;
    lf = lfsr_step(lf);
    am = lf[7:6];
    lf = lfsr_step(lfsr_step(lf));
    h2 = hit_rule(acc_tab[am], lf[3:0]);
    d2 = h2 ? int'(dmg_tab[am]) : 0;
    p_move = mv;
    go = 1'b1;
    @(negedge clk);
    if (!hold) go = 1'b0;
    check("lookup_state", state, ST_P_LOOKUP);
    check("lookup_busy", busy, 1);
    @(negedge clk);
    if (busy_pulse) go = 1'b1;
    @(negedge clk);
    if (busy_pulse) go = hold;
    m_ai = sat(m_ai, d1);
    check("p_turn_ai_hp", ai_hp, m_ai);
    check("p_turn_hit", hit, h1);
    check("p_turn_last_dmg", last_dmg, d1);
    check("p_turn_state", state, ST_P_CHECK);
    if (m_ai == 0) begin
      @(negedge clk);
      m_over = 1;
      check("win_state", state, ST_WIN);
      check("win_victory", victory, 1);
      check("win_loss", loss, 0);
      check("win_p_hp", p_hp, m_p);
      check("win_busy", busy, 0);
      return;
    end
    @(negedge clk);
    check("ai_move_sel", move_sel, am);
    check("ai_lookup_state", state, ST_AI_LOOKUP);
    @(negedge clk);
    check("ai_trainer", active_trainer, 1);
    @(negedge clk);
    m_p = sat(m_p, d2);
    check("ai_turn_p_hp", p_hp, m_p);
    check("ai_turn_hit", hit, h2);
    check("ai_turn_last_dmg", last_dmg, d2);
    @(negedge clk);
    if (m_p == 0) begin
      m_over = 2;
      check("lose_state", state, ST_LOSE);
      check("lose_loss", loss, 1);
      check("lose_victory", victory, 0);
      return;
    end
    check("end_state", state, ST_P_WAIT);
    check("end_busy", busy, 0);
    check("end_trainer", active_trainer, 0);
  endtask

  task automatic new_game();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("ng_idle", state, ST_IDLE);
    check("ng_flags", {victory, loss}, 0);
    @(negedge clk);
    check("ng_state", state, ST_P_WAIT);
    check("ng_p_hp", p_hp, 15);
    check("ng_ai_hp", ai_hp, 15);
    m_p = 15; m_ai = 15; m_over = 0;
  endtask

  initial begin
    set_tab(4'd5, 4'd15);
    // test 1: reset release
    apply_reset();

    // test 2: guaranteed hits
    run_round(2'd1, 1'b0, 1'b0);
    check("t2_ai_hp", ai_hp, 10);
    check("t2_p_hp", p_hp, 10);

    // test 3: zero accuracy never hits
    set_tab(4'd5, 4'd0);
    run_round(2'd2, 1'b0, 1'b0);
    check("t3_hit", hit, 0);
    check("t3_ai_hp", ai_hp, 10);

    // test 4: KO on second round, no AI turn after
    apply_reset();
    set_tab(4'd9, 4'd15);
    run_round(2'd0, 1'b0, 1'b0);
    check("t4_ai_hp", ai_hp, 6);
    run_round(2'd3, 1'b0, 1'b0);
    check("t4_victory", victory, 1);
    check("t4_p_hp", p_hp, 6);
    new_game();

    // test 5: go held high gives one round; busy pulse ignored
    set_tab(4'd5, 4'd15);
    run_round(2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 23; i++) @(negedge clk);
    check("t5_hold_state", state, ST_P_WAIT);
    check("t5_hold_ai_hp", ai_hp, 10);
    go = 1'b0;
    @(negedge clk);
    run_round(2'd2, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("t5_no_extra", state, ST_P_WAIT);
    check("t5_ai_hp", ai_hp, m_ai);

    // test 6: async reset during AI_APPLY
    set_tab(4'd3, 4'd15);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_ai_apply", state, ST_AI_APPLY);
    #2 reset_n = 1'b0;
    #1;
    check("t6_state", state, ST_IDLE);
    check("t6_p_hp", p_hp, 15);
    check("t6_ai_hp", ai_hp, 15);
    check("t6_trainer", active_trainer, 0);
    check("t6_move_sel", move_sel, 0);
    check("t6_last_dmg", last_dmg, 0);
    check("t6_hit", hit, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_p = 15; m_ai = 15; m_over = 0;
    @(negedge clk);
    wait_p_wait("t6_rel_state");
    // first round after reset exercises the reseeded roll sequence
    set_tab(4'd4, 4'd8);
    run_round(2'd0, 1'b0, 1'b0);

    // randomized games
    for (int r = 0; r < 150; r++) begin
      if (m_over != 0) begin
        new_game();
      end else begin
        for (int i = 0; i < 4; i++) begin
          dmg_tab[i] = 4'($urandom_range(0, 15));
          acc_tab[i] = 4'($urandom_range(0, 15));
        end
        run_round(2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
        @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
